// File: rtl/framed_readout_serializer_if.sv
// Pixel measurement buses and control/status handshake for the framed readout serializer.
interface framed_readout_serializer_if #(
   parameter int NUM_PIXELS   = 64,
   parameter int COUNTER_BITS = 16,
   parameter int NUM_LANES    = 8
);
   logic [NUM_PIXELS*COUNTER_BITS-1:0] TIME_HIGH;
   logic [NUM_PIXELS*COUNTER_BITS-1:0] TIME_LOW;
   logic [NUM_PIXELS*COUNTER_BITS-1:0] PERIOD;
   logic [1:0]                         MODE;
   logic                               START;
   logic                               CONTINUOUS;
   logic                               BUSY;
   logic                               FRAME_VALID;
   logic [NUM_LANES-1:0]               DATA_OUT;
   logic                               FRAME_DONE;
   logic [7:0]                         FRAME_ID;

   modport slave (
      input  TIME_HIGH, TIME_LOW, PERIOD, MODE, START, CONTINUOUS,
      output BUSY, FRAME_VALID, DATA_OUT, FRAME_DONE, FRAME_ID
   );

   modport master (
      output TIME_HIGH, TIME_LOW, PERIOD, MODE, START, CONTINUOUS,
      input  BUSY, FRAME_VALID, DATA_OUT, FRAME_DONE, FRAME_ID
   );
endinterface

// File: rtl/framed_readout_serializer.sv
// Snapshots pixel measurement buses on START and streams framed words (header, frame ID,
// payload) over NUM_LANES serial pins, with optional back-to-back continuous re-arm.
//
// state | meaning
// IDLE  | waiting for START, outputs quiet
// HDR   | sending sync header on every lane, MSB first
// FID   | sending 8-bit frame ID on every lane, MSB first
// PAY   | each lane sends its slice of snapshotted pixel words, MSB first
module framed_readout_serializer #(
   parameter int                     NUM_PIXELS   = 64,
   parameter int                     COUNTER_BITS = 16,
   parameter int                     NUM_LANES    = 8,
   parameter int                     HEADER_BITS  = 8,
   parameter logic [HEADER_BITS-1:0] HEADER_WORD  = 8'hA5
) (
   input logic                       CLK,
   input logic                       RST_N,
   framed_readout_serializer_if.slave bus
);
   localparam int PPL  = NUM_PIXELS / NUM_LANES;
   localparam int MAXB = (HEADER_BITS > COUNTER_BITS) ? ((HEADER_BITS > 8) ? HEADER_BITS : 8)
                                                      : ((COUNTER_BITS > 8) ? COUNTER_BITS : 8);
   localparam int BW   = $clog2(MAXB);
   localparam int WDW  = $clog2(3 * PPL);
   localparam int PXW  = (PPL > 1) ? $clog2(PPL) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_FID  = 2'd2;
   localparam logic [1:0] S_PAY  = 2'd3;

   localparam logic [1:0] SEL_HI  = 2'd0;
   localparam logic [1:0] SEL_LO  = 2'd1;
   localparam logic [1:0] SEL_PER = 2'd2;

   generate
      if (NUM_PIXELS % NUM_LANES != 0) begin : g_bad_cfg
         $error("NUM_PIXELS must be a multiple of NUM_LANES");
      end
   endgenerate

   logic [1:0]              r_state;
   logic [BW-1:0]           r_bit;
   logic [WDW-1:0]          r_words;
   logic [PXW-1:0]          r_pix;
   logic [1:0]              r_sel;
   logic [1:0]              r_mode;
   logic [7:0]              r_fid;
   logic                    r_done;
   logic [COUNTER_BITS-1:0] r_sh_hi  [NUM_PIXELS];
   logic [COUNTER_BITS-1:0] r_sh_lo  [NUM_PIXELS];
   logic [COUNTER_BITS-1:0] r_sh_per [NUM_PIXELS];

   logic                 w_end;
   logic                 w_load;
   logic [1:0]           w_sel_init;
   logic                 w_hdr_bit;
   logic                 w_fid_bit;
   logic [NUM_LANES-1:0] w_data;

   assign w_end  = (r_state == S_PAY) && (r_bit == '0) && (r_words == '0);
   // START is only honoured from IDLE; at end of frame only CONTINUOUS re-arms.
   assign w_load = ((r_state == S_IDLE) && bus.START) || (w_end && bus.CONTINUOUS);

   always_comb begin
      case (r_mode)
         2'd0:    w_sel_init = SEL_PER;
         2'd2:    w_sel_init = SEL_LO;
         default: w_sel_init = SEL_HI;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mode <= '0;
         for (int p = 0; p < NUM_PIXELS; p++) begin
            r_sh_hi[p]  <= '0;
            r_sh_lo[p]  <= '0;
            r_sh_per[p] <= '0;
         end
      end else if (w_load) begin
         r_mode <= bus.MODE;
         for (int p = 0; p < NUM_PIXELS; p++) begin
            r_sh_hi[p]  <= bus.TIME_HIGH[p*COUNTER_BITS +: COUNTER_BITS];
            r_sh_lo[p]  <= bus.TIME_LOW[p*COUNTER_BITS +: COUNTER_BITS];
            r_sh_per[p] <= bus.PERIOD[p*COUNTER_BITS +: COUNTER_BITS];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_bit   <= '0;
         r_words <= '0;
         r_pix   <= '0;
         r_sel   <= '0;
         r_fid   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_state <= S_HDR;
                  r_bit   <= BW'(HEADER_BITS - 1);
               end
            end
            S_HDR: begin
               if (r_bit == '0) begin
                  r_state <= S_FID;
                  r_bit   <= BW'(7);
               end else begin
                  r_bit <= r_bit - 1'b1;
               end
            end
            S_FID: begin
               if (r_bit == '0) begin
                  r_state <= S_PAY;
                  r_bit   <= BW'(COUNTER_BITS - 1);
                  r_words <= (r_mode == 2'd3) ? WDW'(3 * PPL - 1) : WDW'(PPL - 1);
                  r_pix   <= '0;
                  r_sel   <= w_sel_init;
               end else begin
                  r_bit <= r_bit - 1'b1;
               end
            end
            S_PAY: begin
               if (r_bit != '0) begin
                  r_bit <= r_bit - 1'b1;
               end else if (r_words == '0) begin
                  r_done <= 1'b1;
                  r_fid  <= r_fid + 1'b1;
                  if (w_load) begin
                     r_state <= S_HDR;
                     r_bit   <= BW'(HEADER_BITS - 1);
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_words <= r_words - 1'b1;
                  r_bit   <= BW'(COUNTER_BITS - 1);
                  // triple mode walks HIGH, LOW, PERIOD before moving to the next pixel
                  if (r_mode == 2'd3 && r_sel != SEL_PER) begin
                     r_sel <= r_sel + 1'b1;
                  end else begin
                     r_sel <= (r_mode == 2'd3) ? SEL_HI : r_sel;
                     r_pix <= r_pix + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      logic [HEADER_BITS-1:0] v_hdr;
      logic [7:0]             v_fid;
      v_hdr     = HEADER_WORD >> r_bit;
      v_fid     = r_fid >> r_bit;
      w_hdr_bit = v_hdr[0];
      w_fid_bit = v_fid[0];
   end

   always_comb begin
      logic [COUNTER_BITS-1:0] v_word;
      logic [COUNTER_BITS-1:0] v_shift;
      v_word  = '0;
      v_shift = '0;
      w_data  = '0;
      case (r_state)
         S_HDR: w_data = {NUM_LANES{w_hdr_bit}};
         S_FID: w_data = {NUM_LANES{w_fid_bit}};
         S_PAY: begin
            for (int n = 0; n < NUM_LANES; n++) begin
               v_word = '0;
               for (int k = 0; k < PPL; k++) begin
                  if (r_pix == PXW'(k)) begin
                     case (r_sel)
                        SEL_HI:  v_word = r_sh_hi[n*PPL + k];
                        SEL_LO:  v_word = r_sh_lo[n*PPL + k];
                        default: v_word = r_sh_per[n*PPL + k];
                     endcase
                  end
               end
               v_shift   = v_word >> r_bit;
               w_data[n] = v_shift[0];
            end
         end
         default: w_data = '0;
      endcase
   end

   assign bus.BUSY        = (r_state != S_IDLE);
   assign bus.FRAME_VALID = (r_state != S_IDLE);
   assign bus.DATA_OUT    = w_data;
   assign bus.FRAME_DONE  = r_done;
   assign bus.FRAME_ID    = r_fid;
endmodule

// File: tb/tb_framed_readout_serializer.sv
// Randomised scoreboard bench: frames are built from a per-lane bit-list model and checked
// cycle by cycle by an independent monitor.
module tb_framed_readout_serializer;
   localparam int NP  = 4;
   localparam int NL  = 2;
   localparam int CB  = 4;
   localparam int PPL = NP / NL;
   localparam logic [7:0] HDR = 8'hA5;

   typedef struct {
      logic [NL-1:0] data;
      bit            last;
      logic [7:0]    fid_next;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   framed_readout_serializer_if #(.NUM_PIXELS(NP), .COUNTER_BITS(CB), .NUM_LANES(NL)) bus ();

   framed_readout_serializer #(
      .NUM_PIXELS(NP), .COUNTER_BITS(CB), .NUM_LANES(NL)
   ) dut (
      .CLK(clk),
      .RST_N(rst_n),
      .bus(bus.slave)
   );

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [CB-1:0] th [NP];
   logic [CB-1:0] tl [NP];
   logic [CB-1:0] tp [NP];
   logic [1:0]    md;
   logic [7:0]    m_fid;
   logic [127:0]  cap0, cap1;
   bit            done_pend;
   logic [7:0]    done_fid;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic drive_inputs();
      for (int p = 0; p < NP; p++) begin
         bus.TIME_HIGH[p*CB +: CB] = th[p];
         bus.TIME_LOW[p*CB +: CB]  = tl[p];
         bus.PERIOD[p*CB +: CB]    = tp[p];
      end
      bus.MODE = md;
   endtask

   task automatic rand_inputs();
      md = 2'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++) begin
         th[p] = CB'($urandom_range(0, (1 << CB) - 1));
         tl[p] = CB'($urandom_range(0, (1 << CB) - 1));
         tp[p] = CB'($urandom_range(0, (1 << CB) - 1));
      end
      drive_inputs();
   endtask

   // Reference frame: each lane is an ordered bit list (header, ID, its pixel words).
   task automatic push_frame(output int len);
      bit            lb [NL][128];
      logic [CB-1:0] w [3];
      int            nw;
      int            pos;
      exp_t          e;
      for (int n = 0; n < NL; n++) begin
         pos = 0;
         for (int i = 7; i >= 0; i--) begin lb[n][pos] = HDR[i]; pos++; end
         for (int i = 7; i >= 0; i--) begin lb[n][pos] = m_fid[i]; pos++; end
         for (int k = 0; k < PPL; k++) begin
            int p = n * PPL + k;
            case (md)
               2'd0: begin w[0] = tp[p]; nw = 1; end
               2'd1: begin w[0] = th[p]; nw = 1; end
               2'd2: begin w[0] = tl[p]; nw = 1; end
               default: begin w[0] = th[p]; w[1] = tl[p]; w[2] = tp[p]; nw = 3; end
            endcase
            for (int j = 0; j < nw; j++)
               for (int b = CB - 1; b >= 0; b--) begin lb[n][pos] = w[j][b]; pos++; end
         end
         len = pos;
      end
      for (int c = 0; c < len; c++) begin
         for (int n = 0; n < NL; n++) e.data[n] = lb[n][c];
         e.last     = (c == len - 1);
         e.fid_next = m_fid + 8'd1;
         exp_q.push_back(e);
      end
      m_fid = m_fid + 8'd1;
   endtask

   task automatic run_frames(input int nframes, input bit pulse_mid, input bit do_rand);
      int len;
      int len_next;
      @(negedge clk);
      if (do_rand) rand_inputs();
      bus.START      = 1'b1;
      bus.CONTINUOUS = (nframes > 1);
      push_frame(len_next);
      cap0 = '0;
      cap1 = '0;
      for (int f = 0; f < nframes; f++) begin
         len = len_next;
         for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            chk("frame_valid", bus.FRAME_VALID, 1);
            if (f == 0) begin
               cap0 = {cap0[126:0], bus.DATA_OUT[0]};
               cap1 = {cap1[126:0], bus.DATA_OUT[1]};
            end
            if (c == 1) bus.START = 1'b0;
            if (c == len / 2) rand_inputs();
            if (pulse_mid && c == len - 3) bus.START = 1'b1;
            if (pulse_mid && c == len - 2) bus.START = 1'b0;
            if (c == len) begin
               bus.CONTINUOUS = (f < nframes - 1);
               bus.START      = (f < nframes - 1);
               if (f < nframes - 1) push_frame(len_next);
            end
         end
      end
      bus.START = 1'b0;
      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 0);
      chk("idle_busy", bus.BUSY, 0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         done_pend = 1'b0;
         chk("rst_outputs", {bus.DATA_OUT, bus.BUSY, bus.FRAME_VALID, bus.FRAME_DONE, bus.FRAME_ID}, 0);
      end else begin
         chk("frame_done", bus.FRAME_DONE, done_pend);
         if (done_pend) chk("frame_id_at_done", bus.FRAME_ID, done_fid);
         done_pend = 1'b0;
         if (bus.FRAME_VALID) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame actual=valid required=idle t=%0t", $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("data_out", bus.DATA_OUT, mon_e.data);
               chk("busy", bus.BUSY, 1);
               if (mon_e.last) begin
                  done_pend = 1'b1;
                  done_fid  = mon_e.fid_next;
               end
            end
         end else begin
            chk("idle_outputs", {bus.DATA_OUT, bus.BUSY}, 0);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int len;
      rst_n = 1'b0;
      m_fid = 8'd0;
      md    = 2'd0;
      for (int p = 0; p < NP; p++) begin th[p] = '0; tl[p] = '0; tp[p] = '0; end
      drive_inputs();
      bus.START      = 1'b0;
      bus.CONTINUOUS = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_frame_id", bus.FRAME_ID, 0);
      chk("reset_valid", bus.FRAME_VALID, 0);

      // period mode, known pixel values
      for (int p = 0; p < NP; p++) begin
         tp[p] = CB'(p + 1);
         th[p] = CB'($urandom_range(0, 15));
         tl[p] = CB'($urandom_range(0, 15));
      end
      md = 2'd0;
      drive_inputs();
      run_frames(1, 0, 0);
      chk("t2_lane0", cap0[23:0], 24'hA50012);
      chk("t2_lane1", cap1[23:0], 24'hA50034);
      chk("t2_frame_id", bus.FRAME_ID, 1);

      // triple mode; inputs and MODE are re-randomised mid-frame inside run_frames
      rand_inputs();
      md = 2'd3;
      th[0] = 4'h5;
      tl[0] = 4'h6;
      tp[0] = 4'hB;
      drive_inputs();
      run_frames(1, 0, 0);
      chk("t3_lane0_payload", cap0[23:12], 12'h56B);

      run_frames(3, 0, 1);
      run_frames(1, 1, 1);
      for (int i = 0; i < 6; i++)
         run_frames($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1);

      // asynchronous reset in the middle of the payload
      @(negedge clk);
      rand_inputs();
      bus.START = 1'b1;
      push_frame(len);
      @(negedge clk);
      bus.START = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_data", bus.DATA_OUT, 0);
      chk("async_rst_busy", bus.BUSY, 0);
      chk("async_rst_valid", bus.FRAME_VALID, 0);
      chk("async_rst_id", bus.FRAME_ID, 0);
      chk("async_rst_done", bus.FRAME_DONE, 0);
      m_fid = 8'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frames(1, 0, 1);
      chk("post_rst_frame_id", bus.FRAME_ID, 1);

      // long continuous run crossing the 255 -> 0 frame ID wrap
      run_frames(258, 0, 1);
      chk("wrap_frame_id", bus.FRAME_ID, 8'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
